usb_tx_serializer: RTL and testbench

Parametrised USB full-speed transmit serializer: accepts packet bytes over a valid/ready handshake and drives the bus lines. Adds per-bit timing, optional SYNC generation, bit stuffing, NRZI encoding and EOP generation. Sits between the packet-assembly logic (PID/CRC builder) and the D+/D− output drivers, in the slot previously filled by a plain parallel-to-serial register.

---
 rtl/usb_tx_serializer.sv | 228 ++++++++++++++++++++++
 tb/tb_usb_tx_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_serializer.sv
// USB full-speed transmit serializer: bit timing, bit stuffing, NRZI and EOP generation.
// Optional feature macro: USB_TX_SYNC_EN (block generates the SYNC field itself).
module usb_tx_serializer #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_PERIOD = 8,
    parameter int unsigned STUFF_LEN  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_enable,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              d_plus,
    output logic              d_minus,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_err
);
    localparam int unsigned TW = $clog2(BIT_PERIOD);
    localparam int unsigned BW = $clog2(DATA_W);
    localparam int unsigned SW = $clog2(STUFF_LEN + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_PERIOD - 1);
    localparam logic [BW-1:0] WORD_LAST  = BW'(DATA_W - 1);
    localparam logic [SW-1:0] STUFF_PRE  = SW'(STUFF_LEN - 1);
`ifdef USB_TX_SYNC_EN
    localparam logic [7:0]    SYNC_PAT   = 8'h80;
`endif

    typedef enum logic [2:0] {
        IDLE,
`ifdef USB_TX_SYNC_EN
        SYNC,
`endif
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t            r_state, w_nxt;
    logic [TW-1:0]     r_timer;
    logic [DATA_W-1:0] r_hold, r_shift;
    logic              r_hold_full, r_hold_last, r_last_seen, r_shift_last;
    logic [BW-1:0]     r_bitcnt;
    logic [SW-1:0]     r_stuffcnt;
    logic [2:0]        r_sub;
    logic              r_stuff_eop, r_abort, r_nrzi, r_dp, r_dm, r_done, r_err;

    logic w_tick, w_feed, w_boundary, w_accept, w_data_hit, w_line;
    logic w_start, w_load, w_emit, w_bit, w_se0, w_j, w_underrun, w_fin, w_stuff_eop;

    assign w_tick     = (r_timer == TIMER_LAST);
    assign w_boundary = (r_state == DATA) && w_tick && (r_bitcnt == WORD_LAST);
    assign w_data_hit = r_shift[0] && (r_stuffcnt == STUFF_PRE);
    assign w_accept   = tx_valid && tx_ready;
    assign w_line     = w_bit ? r_nrzi : ~r_nrzi;
`ifdef USB_TX_SYNC_EN
    assign w_feed = (r_state == SYNC) || (r_state == DATA) || (r_state == STUFF);
`else
    assign w_feed = (r_state == DATA) || (r_state == STUFF);
`endif

    // Ready drops on the boundary tick so a word cannot land in the holding
    // register in the same cycle the FSM decides the packet is ending.
    always_comb begin
        tx_ready = 1'b0;
        if (!rst) begin
            if (r_state == IDLE)
                tx_ready = tx_enable && !r_hold_full;
            else if (w_feed)
                tx_ready = !r_hold_full && !r_last_seen && !w_boundary;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt       = r_state;
        w_start     = 1'b0;
        w_load      = 1'b0;
        w_emit      = 1'b0;
        w_bit       = 1'b0;
        w_se0       = 1'b0;
        w_j         = 1'b0;
        w_underrun  = 1'b0;
        w_fin       = 1'b0;
        w_stuff_eop = 1'b0;
        case (r_state)
            IDLE: if (r_hold_full) begin
                w_start = 1'b1;
                w_load  = 1'b1;
`ifdef USB_TX_SYNC_EN
                w_nxt   = SYNC;
`else
                w_nxt   = DATA;
`endif
            end
`ifdef USB_TX_SYNC_EN
            SYNC: if (w_tick) begin
                w_emit = 1'b1;
                w_bit  = SYNC_PAT[r_sub];
                if (w_bit && (r_stuffcnt == STUFF_PRE)) w_nxt = STUFF;
                else if (r_sub == 3'd7)                 w_nxt = DATA;
            end
`endif
            DATA: if (w_tick) begin
                w_emit = 1'b1;
                w_bit  = r_shift[0];
                if (r_bitcnt != WORD_LAST) begin
                    w_nxt = w_data_hit ? STUFF : DATA;
                end else if (r_hold_full) begin
                    w_load = 1'b1;
                    w_nxt  = w_data_hit ? STUFF : DATA;
                end else if (r_shift_last) begin
                    w_stuff_eop = 1'b1;
                    w_nxt       = w_data_hit ? STUFF : EOP_SE0;
                end else begin
                    w_underrun = 1'b1;
                    w_nxt      = EOP_SE0;
                end
            end
            STUFF: if (w_tick) begin
                w_emit = 1'b1;
                w_bit  = 1'b0;
                w_nxt  = r_stuff_eop ? EOP_SE0 : DATA;
            end
            EOP_SE0: if (w_tick) begin
                w_se0 = 1'b1;
                if (r_sub == 3'd1) w_nxt = EOP_J;
            end
            // First tick drives J; the following tick ends the J bit time.
            EOP_J: if (w_tick) begin
                if (r_sub == 3'd1) begin
                    w_fin = 1'b1;
                    w_nxt = IDLE;
                end else begin
                    w_j = 1'b1;
                end
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer      <= '0;
            r_hold       <= '0;
            r_hold_full  <= 1'b0;
            r_hold_last  <= 1'b0;
            r_last_seen  <= 1'b0;
            r_shift      <= '0;
            r_shift_last <= 1'b0;
            r_bitcnt     <= '0;
            r_stuffcnt   <= '0;
            r_sub        <= '0;
            r_stuff_eop  <= 1'b0;
            r_abort      <= 1'b0;
            r_nrzi       <= 1'b1;
            r_dp         <= 1'b1;
            r_dm         <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= w_fin && !r_abort;
            r_err  <= w_underrun;

            if (r_state == IDLE) r_timer <= w_start ? TIMER_LAST : '0;
            else if (w_tick)     r_timer <= '0;
            else                 r_timer <= r_timer + TW'(1);

            if (w_nxt != r_state) r_sub <= '0;
            else if (w_tick)      r_sub <= r_sub + 3'd1;

            if (w_accept) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
                r_hold_last <= tx_last;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_accept && tx_last) r_last_seen <= 1'b1;
            else if (w_fin)          r_last_seen <= 1'b0;

            if (w_load) begin
                r_shift      <= r_hold;
                r_shift_last <= r_hold_last;
                r_bitcnt     <= '0;
            end else if ((r_state == DATA) && w_tick) begin
                r_shift  <= r_shift >> 1;
                r_bitcnt <= r_bitcnt + BW'(1);
            end

            if ((w_nxt == STUFF) && (r_state != STUFF)) r_stuff_eop <= w_stuff_eop;

            if (w_start)         r_abort <= 1'b0;
            else if (w_underrun) r_abort <= 1'b1;

            if (w_start) begin
                r_stuffcnt <= '0;
                r_nrzi     <= 1'b1;
            end else if (w_emit) begin
                r_stuffcnt <= w_bit ? r_stuffcnt + SW'(1) : '0;
                r_nrzi     <= w_line;
                r_dp       <= w_line;
                r_dm       <= ~w_line;
            end else if (w_se0) begin
                r_dp <= 1'b0;
                r_dm <= 1'b0;
            end else if (w_j) begin
                r_dp   <= 1'b1;
                r_dm   <= 1'b0;
                r_nrzi <= 1'b1;
            end
        end
    end

    assign d_plus  = r_dp;
    assign d_minus = r_dm;
    assign tx_busy = (r_state != IDLE);
    assign tx_done = r_done;
    assign tx_err  = r_err;
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench for usb_tx_serializer: a reference model queues expected line symbols
// per packet; a monitor samples the bus mid-bit and checks EOP/done/err timing.
module tb_usb_tx_serializer;
    localparam int BP    = 4;
    localparam int STUFF = 6;

    logic       clk, rst, tx_enable, tx_valid, tx_last;
    logic [7:0] tx_data;
    logic       tx_ready, d_plus, d_minus, tx_busy, tx_done, tx_err;

    usb_tx_serializer #(.DATA_W(8), .BIT_PERIOD(BP), .STUFF_LEN(STUFF)) dut (
        .clk(clk), .rst(rst), .tx_enable(tx_enable), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .d_plus(d_plus), .d_minus(d_minus), .tx_busy(tx_busy),
        .tx_done(tx_done), .tx_err(tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_err = 0, n_chk = 0, pkts = 0, n_done = 0, n_errp = 0;
    bit         mon_en = 0;
    logic [1:0] exp_q[$];
    int         len_q[$];
    bit         ok_q[$];
    logic [7:0] pkt[$];
    logic       m_nz;
    int         m_ones, m_len;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_push(input logic b);
        m_nz = b ? m_nz : ~m_nz;
        exp_q.push_back({m_nz, ~m_nz});
        m_len++;
        m_ones = b ? m_ones + 1 : 0;
    endtask

    task automatic m_bit(input logic b, input bit allow_stuff);
        m_push(b);
        if (allow_stuff && m_ones == STUFF) m_push(1'b0);
    endtask

    task automatic model_packet(input bit underrun);
        logic [7:0] w;
        m_nz = 1'b1; m_ones = 0; m_len = 0;
`ifdef USB_TX_SYNC_EN
        w = 8'h80;
        for (int b = 0; b < 8; b++) m_bit(w[b], 1'b1);
`endif
        for (int i = 0; i < pkt.size(); i++) begin
            w = pkt[i];
            for (int b = 0; b < 8; b++)
                m_bit(w[b], !(underrun && i == pkt.size() - 1 && b == 7));
        end
        exp_q.push_back(2'b00); exp_q.push_back(2'b00); exp_q.push_back(2'b10);
        len_q.push_back(m_len + 3);
        ok_q.push_back(!underrun);
    endtask

    task automatic mstep();
        @(negedge clk);
        if (tx_done) n_done++;
        if (tx_err)  n_errp++;
    endtask

    // Entered on the first negedge with tx_busy high (cycle t+1).
    task automatic run_packet();
        int len; bit ok; logic [1:0] e;
        n_done = 0; n_errp = 0;
        if (len_q.size() == 0) begin
            check("pkt_expected", 32'd0, 32'd1);
            return;
        end
        len = len_q.pop_front();
        ok  = ok_q.pop_front();
        repeat (1 + BP/2) mstep();
        for (int k = 0; k < len; k++) begin
            e = exp_q.pop_front();
            check($sformatf("pkt%0d_line%0d", pkts, k), {30'd0, d_plus, d_minus}, {30'd0, e});
            if (k < len - 1) repeat (BP) mstep();
        end
        repeat (BP - BP/2) mstep();
        check("done_at_eop_end", tx_done, ok);
        check("busy_low_at_end", tx_busy, 0);
        check("done_pulses", n_done, ok);
        check("err_pulses", n_errp, !ok);
        pkts++;
    endtask

    initial begin : monitor
        bit prev_busy;
        prev_busy = 0;
        forever begin
            @(negedge clk);
            if (mon_en && tx_busy && !prev_busy) run_packet();
            prev_busy = tx_busy;
        end
    end

    task automatic send_word(input logic [7:0] d, input logic last);
        bit ok;
        tx_valid = 1'b1; tx_data = d; tx_last = last;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                ok = 1;
            end
            @(negedge clk);
        end
        check("word_accepted", ok, 1);
    endtask

    task automatic send_pkt(input bit with_last, input bit drop_en, input bit hold_after);
        for (int i = 0; i < pkt.size(); i++) begin
            send_word(pkt[i], with_last && (i == pkt.size() - 1));
            if (i == 0 && drop_en) tx_enable = 1'b0;
        end
        tx_last = 1'b0;
        if (hold_after) tx_data = 8'h55;
        else            tx_valid = 1'b0;
    endtask

    task automatic wait_pkt(input int target, output int rdy_hi);
        rdy_hi = 0;
        for (int i = 0; i < 20000 && pkts < target; i++) begin
            @(negedge clk);
            if (tx_ready) rdy_hi++;
        end
        check("pkt_complete", 32'(pkts >= target), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : main
        int rdy, quiet;
        rst = 1'b1; tx_enable = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_last = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dplus", d_plus, 1);
        check("rst_dminus", d_minus, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_err", tx_err, 0);
        check("rst_ready", tx_ready, 0);
        rst = 1'b0; tx_enable = 1'b0; #1;
        check("idle_ready_en0", tx_ready, 0);
        tx_enable = 1'b1; #1;
        check("idle_ready_en1", tx_ready, 1);

        // Reset in the middle of a byte.
        @(negedge clk);
        send_word(8'hA5, 1'b1);
        tx_valid = 1'b0; tx_last = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_busy", tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dplus", d_plus, 1);
        check("midrst_dminus", d_minus, 0);
        check("midrst_busy", tx_busy, 0);
        check("midrst_done", tx_done, 0);
        rst = 1'b0; #1;
        check("postrst_ready", tx_ready, tx_enable);
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_busy || tx_done || tx_err) quiet++;
        end
        check("postrst_quiet", quiet, 0);

        mon_en = 1;
        pkt = '{8'hC3};             model_packet(0); send_pkt(1, 0, 0); wait_pkt(1, rdy);
        pkt = '{8'hFF, 8'h01};      model_packet(0); send_pkt(1, 0, 0); wait_pkt(2, rdy);
        pkt = '{8'hFC};             model_packet(0); send_pkt(1, 0, 0); wait_pkt(3, rdy);
        pkt = '{8'h2D};             model_packet(1); send_pkt(0, 0, 0); wait_pkt(4, rdy);

        // Back-to-back words, enable dropped after the first; valid stays high afterwards.
        pkt = '{8'hFC, 8'hFF, 8'h3C, 8'h7E};
        model_packet(0); send_pkt(1, 1, 1); wait_pkt(5, rdy);
        check("bp_ready_after_last", rdy, 0);
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_busy || tx_ready) quiet++;
        end
        check("bp_no_restart", quiet, 0);
        tx_valid = 1'b0; tx_enable = 1'b1;
        @(negedge clk);

        pkt = '{8'h00};             model_packet(0); send_pkt(1, 0, 0); wait_pkt(6, rdy);
        check("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
